// File: rtl/fp32_pkg.sv
// Shared constants, FSM states and the unpacked-operand bundle
// for the float-to-integer converter.
package fp32_pkg;

  localparam int FRAC_W = 23;
  localparam int EXP_W  = 8;

  localparam logic [EXP_W-1:0] BIAS        = 8'd127;
  localparam logic [EXP_W-1:0] EXP_MAX     = 8'd255;
  localparam logic [EXP_W-1:0] INT_EXP_MAX = 8'd158;
  localparam logic [EXP_W-1:0] EXP_UNIT    = 8'd150;

  localparam logic [31:0] QNAN_SAT = 32'h7FFF_FFFF;
  localparam logic [31:0] NEG_SAT  = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  typedef struct packed {
    logic        sign;
    logic [23:0] mant;
    logic        dir;
    logic [4:0]  n;
    logic        forced;
    logic [31:0] res;
    logic        ovf;
    logic        inx;
  } unpack_t;

endpackage

// File: rtl/fp32_unpack.sv
// Classifies a single-precision float and derives the shift
// plan or the forced result for integer conversion.
module fp32_unpack
  import fp32_pkg::*;
(
  input  logic [31:0] in_data,
  output unpack_t     u
);

  logic              sign;
  logic [EXP_W-1:0]  exp;
  logic [FRAC_W-1:0] frac;
  logic [EXP_W-1:0]  d_right;
  logic [EXP_W-1:0]  d_left;
  logic              is_special;
  logic              is_small;
  logic              is_big;
  logic              is_right;
  logic              is_left;
  logic              is_min_int;

  assign sign = in_data[31];
  assign exp  = in_data[FRAC_W +: EXP_W];
  assign frac = in_data[FRAC_W-1:0];

  assign d_right = EXP_UNIT - exp;
  assign d_left  = exp - EXP_UNIT;

  // Classes are disjoint so the decoder below stays one-hot.
  assign is_special = (exp == EXP_MAX);
  assign is_small   = (exp < BIAS);
  assign is_big     = (exp >= INT_EXP_MAX) && !is_special;
  assign is_right   = (exp >= BIAS) && (exp < EXP_UNIT);
  assign is_left    = (exp >= EXP_UNIT) && (exp < INT_EXP_MAX);
  assign is_min_int = sign && (exp == INT_EXP_MAX) && (frac == '0);

  always_comb begin
    u        = '0;
    u.sign   = sign;
    u.mant   = {exp != '0, frac};
    unique case (1'b1)
      is_special: begin
        u.forced = 1'b1;
        u.ovf    = 1'b1;
        u.res    = (frac != '0 || !sign) ? QNAN_SAT : NEG_SAT;
      end
      is_small: begin
        u.forced = 1'b1;
        u.res    = '0;
        u.inx    = (exp != '0) || (frac != '0);
      end
      is_big: begin
        u.forced = 1'b1;
        u.ovf    = !is_min_int;
        u.res    = sign ? NEG_SAT : QNAN_SAT;
      end
      is_right: begin
        u.dir = 1'b1;
        u.n   = d_right[4:0];
      end
      is_left: begin
        u.dir = 1'b0;
        u.n   = d_left[4:0];
      end
      default: u.forced = 1'b1;
    endcase
  end

endmodule

// File: rtl/fp_to_int_converter.sv
// Sequential float32 to int32 converter: unpack, iterative
// denormalising shift, sign application, saturation flags.
module fp_to_int_converter
  import fp32_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        overflow,
  output logic        inexact
);

  localparam logic [4:0] STEP_N = 5'(STEP);

  state_t      state;
  state_t      state_nxt;
  unpack_t     u;

  logic [31:0] acc;
  logic [4:0]  remaining;
  logic        dir;
  logic        sign;
  logic        forced;
  logic        sticky;
  logic [31:0] f_res;
  logic        f_ovf;
  logic        f_inx;

  logic        accept;
  logic        last;
  logic [4:0]  amt;
  logic [31:0] shf_mask;
  logic [31:0] acc_shf;
  logic        sticky_nxt;
  logic [31:0] mag_fin;

  fp32_unpack u_unpack (
    .in_data (in_data),
    .u       (u)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  always_comb begin
    last       = (remaining <= STEP_N);
    amt        = last ? remaining : STEP_N;
    shf_mask   = (32'h1 << amt) - 32'h1;
    acc_shf    = dir ? (acc >> amt) : (acc << amt);
    sticky_nxt = sticky | (dir & (|(acc & shf_mask)));
    // Zero stays zero: no negative-zero encoding exists anyway.
    mag_fin    = (sign && acc_shf != '0) ? (~acc_shf + 32'h1)
                                         : acc_shf;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (forced || last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      remaining <= '0;
      dir       <= 1'b0;
      sign      <= 1'b0;
      forced    <= 1'b0;
      sticky    <= 1'b0;
      f_res     <= '0;
      f_ovf     <= 1'b0;
      f_inx     <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
      inexact   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            acc       <= {8'h00, u.mant};
            remaining <= u.n;
            dir       <= u.dir;
            sign      <= u.sign;
            forced    <= u.forced;
            f_res     <= u.res;
            f_ovf     <= u.ovf;
            f_inx     <= u.inx;
            sticky    <= 1'b0;
          end
        end
        SHIFT: begin
          if (forced) begin
            out_data <= f_res;
            overflow <= f_ovf;
            inexact  <= f_inx;
          end else if (last) begin
            out_data <= mag_fin;
            overflow <= 1'b0;
            inexact  <= sticky_nxt;
          end else begin
            acc       <= acc_shf;
            remaining <= remaining - amt;
            sticky    <= sticky_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_to_int_converter.sv
// Scoreboard bench for fp_to_int_converter (STEP=1 main
// instance plus a STEP=4 instance for latency scaling).
module tb_fp_to_int_converter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic        overflow, inexact;

  logic        in_valid4, in_ready4, out_valid4, out_ready4;
  logic [31:0] in_data4, out_data4;
  logic        overflow4, inexact4;

  always #5 clk = ~clk;

  fp_to_int_converter #(.STEP(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .overflow(overflow), .inexact(inexact)
  );

  fp_to_int_converter #(.STEP(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .out_data(out_data4), .overflow(overflow4), .inexact(inexact4)
  );

  typedef struct {
    logic [31:0] data;
    logic        ovf;
    logic        inx;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;

  function automatic exp_t model(input logic [31:0] f, input int step);
    exp_t   r;
    logic   s;
    int     e, n;
    longint m, mag;
    s = f[31];
    e = int'(f[30:23]);
    m = longint'({f[30:23] != 8'd0, f[22:0]});
    r.data = 32'd0; r.ovf = 1'b0; r.inx = 1'b0; r.lat = 1;
    if (e == 255) begin
      r.ovf  = 1'b1;
      r.data = (f[22:0] != 0 || !s) ? 32'h7FFFFFFF : 32'h80000000;
    end else if (e < 127) begin
      r.inx = (f[30:0] != 0);
    end else if (e >= 158) begin
      if (s && e == 158 && f[22:0] == 0) r.data = 32'h80000000;
      else begin
        r.ovf  = 1'b1;
        r.data = s ? 32'h80000000 : 32'h7FFFFFFF;
      end
    end else begin
      if (e >= 150) begin
        n = e - 150;
        mag = m << n;
      end else begin
        n = 150 - e;
        mag = m >> n;
        r.inx = ((m & ((64'sd1 <<< n) - 1)) != 0);
      end
      r.data = s ? 32'(-mag) : 32'(mag);
      r.lat = (n + step - 1) / step;
      if (r.lat < 1) r.lat = 1;
    end
    return r;
  endfunction

  task automatic run(input logic [31:0] f, input int hold);
    exp_t e;
    int   k, lat;
    sb.push_back(model(f, 1));
    k = 0;
    while (!in_ready && k < 50) begin @(posedge clk); #1; k++; end
    in_data = f; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = $urandom;
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    e = sb.pop_front();
    compared++;
    if (!out_valid) begin
      mismatched++;
      $display("FAIL timeout in=%h no out_valid after %0d cycles", f, lat);
      return;
    end
    compared++;
    if (out_data !== e.data) begin
      mismatched++;
      $display("FAIL data in=%h got %h want %h", f, out_data, e.data);
    end
    compared++;
    if (overflow !== e.ovf) begin
      mismatched++;
      $display("FAIL overflow in=%h got %b want %b", f, overflow, e.ovf);
    end
    compared++;
    if (inexact !== e.inx) begin
      mismatched++;
      $display("FAIL inexact in=%h got %b want %b", f, inexact, e.inx);
    end
    compared++;
    if (lat !== e.lat) begin
      mismatched++;
      $display("FAIL latency in=%h got %0d want %0d", f, lat, e.lat);
    end
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; in_data = 32'h3F800000;
      @(posedge clk); #1;
      compared++;
      if (out_data !== e.data || overflow !== e.ovf || inexact !== e.inx) begin
        mismatched++;
        $display("FAIL hold_stable cyc=%0d got %h/%b/%b want %h/%b/%b",
                 i, out_data, overflow, inexact, e.data, e.ovf, e.inx);
      end
      compared++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        mismatched++;
        $display("FAIL hold_hs cyc=%0d got rdy=%b vld=%b want 0/1",
                 i, in_ready, out_valid);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL release got rdy=%b vld=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 0; in_data = 0; out_ready = 0;
    in_valid4 = 0; in_data4 = 0; out_ready4 = 0;
    @(posedge clk); #1;
    compared++;
    if ({in_ready, out_valid, overflow, inexact} !== 4'b1000 || out_data !== 32'd0) begin
      mismatched++;
      $display("FAIL reset got rdy=%b vld=%b ovf=%b inx=%b data=%h want 1 0 0 0 0",
               in_ready, out_valid, overflow, inexact, out_data);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    run(32'h3F800000, 0);
    run(32'hC0490FDB, 0);
    run(32'h40490FDB, 0);
    run(32'hBF800000, 0);
  endtask

  task automatic test_saturate();
    run(32'h4F000000, 0);
    run(32'hCF000000, 0);
    run(32'h4EFFFFFF, 0);
    run(32'hCEFFFFFF, 0);
    run(32'hFF800000, 0);
    run(32'h4F800000, 0);
    run(32'hCF000001, 0);
  endtask

  task automatic test_forced();
    run(32'h7FC00000, 0);
    run(32'hFFC00000, 0);
    run(32'h00000001, 0);
    run(32'h80000000, 0);
    run(32'hBF000000, 0);
  endtask

  task automatic test_hold();
    run(32'h4B7FFFFF, 5);
  endtask

  task automatic test_back_to_back();
    logic [31:0] f;
    for (int i = 0; i < 24; i++) begin
      f = {1'($urandom), 8'(118 + $urandom_range(0, 42)), 23'($urandom)};
      run(f, 0);
    end
  endtask

  task automatic test_reset_mid();
    in_data = 32'h3F800000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    compared++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_mid got vld=%b rdy=%b want 0/1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    run(32'h3F800000, 0);
  endtask

  task automatic test_step4();
    logic [31:0] v[3];
    exp_t e;
    int lat;
    v[0] = 32'hC0490FDB; v[1] = 32'h3F800000; v[2] = 32'h4EFFFFFF;
    for (int i = 0; i < 3; i++) begin
      e = model(v[i], 4);
      in_data4 = v[i]; in_valid4 = 1'b1;
      @(posedge clk); #1;
      in_valid4 = 1'b0;
      lat = 0;
      while (!out_valid4 && lat < 100) begin @(posedge clk); #1; lat++; end
      compared++;
      if (lat !== e.lat) begin
        mismatched++;
        $display("FAIL step4_latency in=%h got %0d want %0d", v[i], lat, e.lat);
      end
      compared++;
      if (out_data4 !== e.data || inexact4 !== e.inx || overflow4 !== e.ovf) begin
        mismatched++;
        $display("FAIL step4_result in=%h got %h/%b/%b want %h/%b/%b",
                 v[i], out_data4, overflow4, inexact4, e.data, e.ovf, e.inx);
      end
      out_ready4 = 1'b1;
      @(posedge clk); #1;
      out_ready4 = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_forced();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_step4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
